// File: rtl/soc_system_ogpu_cmd_req_out.sv
// Avalon-MM slave that hands one command word to the OpenGPU over a 4-phase
// req/ack handshake, with sticky status bits, an optional timeout and a level irq.
module soc_system_ogpu_cmd_req_out #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             req_out,
    input  logic             ack_in,
    output logic             irq
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ACK_LOW
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          ack_m;
    logic          ack_s;
    logic          done;
    logic          err;
    logic          tmo;
    logic          irq_en;

    logic          wr;
    logic          busy;
    logic          start_req;
    logic          busy_wr;
    logic          timeout_hit;
    logic [31:0]   rd_mux;

    assign wr          = chipselect & ~write_n;
    assign busy        = (state != IDLE);
    assign start_req   = wr && (address == 2'd1) && writedata[0];
    // Both a DATA write and a start attempt are rejected while a handshake is in flight.
    assign busy_wr     = busy && ((wr && (address == 2'd0)) || start_req);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);
    assign irq         = done & irq_en;

    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0:    rd_mux = 32'(out_port);
            2'd1:    rd_mux = {28'b0, busy, tmo, err, done};
            2'd2:    rd_mux = {31'b0, irq_en};
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            ack_m    <= 1'b0;
            ack_s    <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            tmo      <= 1'b0;
            irq_en   <= 1'b0;
            req_out  <= 1'b0;
            out_port <= '0;
            readdata <= '0;
        end else begin
            ack_m    <= ack_in;
            ack_s    <= ack_m;
            readdata <= rd_mux;

            if (wr && (address == 2'd0) && !busy)
                out_port <= writedata[WIDTH-1:0];
            if (wr && (address == 2'd2))
                irq_en <= writedata[0];

            // Clears come first so a same-cycle set event below takes priority.
            if (wr && (address == 2'd3)) begin
                if (writedata[0]) done <= 1'b0;
                if (writedata[1]) err  <= 1'b0;
                if (writedata[2]) tmo  <= 1'b0;
            end
            if (busy_wr)
                err <= 1'b1;

            case (state)
                IDLE: begin
                    req_out <= 1'b0;
                    if (start_req) begin
                        state   <= REQ;
                        req_out <= 1'b1;
                        cnt     <= '0;
                    end
                end
                REQ: begin
                    cnt <= cnt + 1'b1;
                    if (ack_s) begin
                        state   <= ACK_LOW;
                        req_out <= 1'b0;
                    end else if (timeout_hit) begin
                        state   <= IDLE;
                        req_out <= 1'b0;
                        tmo     <= 1'b1;
                    end
                end
                ACK_LOW: begin
                    cnt     <= cnt + 1'b1;
                    req_out <= 1'b0;
                    if (!ack_s) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end else if (timeout_hit) begin
                        state <= IDLE;
                        tmo   <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    req_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_soc_system_ogpu_cmd_req_out.sv
// Directed bench for soc_system_ogpu_cmd_req_out with a short timeout so the
// abort path is reachable in a few cycles.
module tb_soc_system_ogpu_cmd_req_out;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [31:0] out_port;
    logic        req_out;
    logic        ack_in;
    logic        irq;

    int unsigned n_cmp = 0;
    int unsigned n_mis = 0;
    logic [31:0] rd;

    always #5 clk = ~clk;

    soc_system_ogpu_cmd_req_out #(
        .WIDTH         (32),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .out_port  (out_port),
        .req_out   (req_out),
        .ack_in    (ack_in),
        .irq       (irq)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a;
        @(posedge clk);
        #1;
        d = readdata;
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        ack_in     = 1'b0;

        #12;
        check_eq("rst_req_out",  32'(req_out), 32'h0);
        check_eq("rst_readdata", readdata,     32'h0);
        check_eq("rst_out_port", out_port,     32'h0);
        check_eq("rst_irq",      32'(irq),     32'h0);
        #10;
        reset_n = 1'b1;

        // Nominal handshake
        bus_wr(2'd0, 32'h0000_00A5);
        check_eq("t2_out_port", out_port, 32'hA5);
        check_eq("t2_req_pre", 32'(req_out), 32'h0);
        bus_wr(2'd1, 32'h1);
        check_eq("t2_req_rise", 32'(req_out), 32'h1);
        clks(4);
        @(negedge clk);
        ack_in = 1'b1;
        clks(1);
        check_eq("t2_req_sync1", 32'(req_out), 32'h1);
        clks(1);
        check_eq("t2_req_sync2", 32'(req_out), 32'h1);
        clks(1);
        check_eq("t2_req_fall", 32'(req_out), 32'h0);
        clks(2);
        @(negedge clk);
        ack_in = 1'b0;
        clks(2);
        bus_rd(2'd1, rd);
        check_eq("t2_busy_acklow", rd, 32'h8);
        bus_rd(2'd1, rd);
        check_eq("t2_status_done", rd, 32'h1);
        bus_rd(2'd0, rd);
        check_eq("t2_data_rd", rd, 32'hA5);
        bus_wr(2'd3, 32'h7);

        // Interrupt
        bus_wr(2'd2, 32'h1);
        check_eq("t3_irq_idle", 32'(irq), 32'h0);
        bus_rd(2'd2, rd);
        check_eq("t3_irqen_rd", rd, 32'h1);
        bus_wr(2'd1, 32'h1);
        clks(2);
        @(negedge clk);
        ack_in = 1'b1;
        clks(4);
        @(negedge clk);
        ack_in = 1'b0;
        clks(4);
        check_eq("t3_irq_set", 32'(irq), 32'h1);
        bus_wr(2'd3, 32'h1);
        check_eq("t3_irq_clr", 32'(irq), 32'h0);

        // Writes while busy
        bus_wr(2'd1, 32'h1);
        bus_wr(2'd0, 32'h0000_003C);
        bus_wr(2'd1, 32'h1);
        check_eq("t4_out_port", out_port, 32'hA5);
        check_eq("t4_req_held", 32'(req_out), 32'h1);
        bus_rd(2'd1, rd);
        check_eq("t4_status_busy_err", rd, 32'hA);
        @(negedge clk);
        ack_in = 1'b1;
        clks(4);
        @(negedge clk);
        ack_in = 1'b0;
        clks(4);
        check_eq("t4_no_second_req", 32'(req_out), 32'h0);
        bus_rd(2'd1, rd);
        check_eq("t4_status_done_err", rd, 32'h3);
        bus_wr(2'd3, 32'h7);
        bus_rd(2'd1, rd);
        check_eq("t4_status_cleared", rd, 32'h0);

        // Timeout with ack held low
        bus_wr(2'd1, 32'h1);
        clks(15);
        check_eq("t5_req_last", 32'(req_out), 32'h1);
        clks(1);
        check_eq("t5_req_drop", 32'(req_out), 32'h0);
        bus_rd(2'd1, rd);
        check_eq("t5_status_tmo", rd, 32'h4);
        bus_wr(2'd3, 32'h4);

        // ack already high when the request starts
        @(negedge clk);
        ack_in = 1'b1;
        clks(3);
        bus_wr(2'd1, 32'h1);
        check_eq("early_ack_req_rise", 32'(req_out), 32'h1);
        clks(1);
        check_eq("early_ack_req_fall", 32'(req_out), 32'h0);
        @(negedge clk);
        ack_in = 1'b0;
        clks(4);
        bus_rd(2'd1, rd);
        check_eq("early_ack_status", rd, 32'h1);
        bus_wr(2'd3, 32'h1);

        // CLEAR of done on the very cycle ACK_LOW completes
        bus_wr(2'd1, 32'h1);
        clks(2);
        @(negedge clk);
        ack_in = 1'b1;
        clks(4);
        @(negedge clk);
        ack_in = 1'b0;
        @(posedge clk);
        @(posedge clk);
        bus_wr(2'd3, 32'h1);
        bus_rd(2'd1, rd);
        check_eq("t6_done_wins", rd, 32'h1);
        check_eq("t6_irq", 32'(irq), 32'h1);

        // Asynchronous reset in the middle of a request
        bus_wr(2'd1, 32'h1);
        bus_rd(2'd1, rd);
        check_eq("t1_status_pre", rd, 32'h9);
        check_eq("t1_req_pre", 32'(req_out), 32'h1);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("t1_req_out", 32'(req_out), 32'h0);
        check_eq("t1_readdata", readdata, 32'h0);
        check_eq("t1_irq", 32'(irq), 32'h0);
        check_eq("t1_out_port", out_port, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        bus_rd(2'd1, rd);
        check_eq("t1_status_post", rd, 32'h0);
        bus_rd(2'd2, rd);
        check_eq("t1_irqen_post", rd, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
